fetch_queue: RTL and testbench

// - Parametrised instruction queue between the fetch stage and decode. Decouples
//   PC generation / icache latency from decode stalls.
// - Tags entries with a fetch epoch and drops stale in-flight responses after a redirect.
// - Adds early back-pressure (almost_full_o) and an optional same-cycle bypass when empty.

---
 rtl/fetch_queue_pkg.sv | 26 ++
 rtl/fetch_queue.sv | 129 ++++++++++++
 tb/tb_fetch_queue.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch -> decode instruction queue.
// Entry layout and default sizing constants.
package fetch_queue_pkg;

  localparam int FQ_XLEN    = 32;
  localparam int FQ_DEPTH   = 4;
  localparam int FQ_EPOCH_W = 2;

  typedef enum logic [2:0] {
    EXC_NONE      = 3'd0,
    EXC_IMISALIGN = 3'd1,
    EXC_IACCESS   = 3'd2,
    EXC_IPAGE     = 3'd3,
    EXC_ILLEGAL   = 3'd4
  } exc_type_e;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] inst;
    logic [FQ_XLEN-1:0] pc_incr;
    exc_type_e          exc;
    logic               taken;
    logic [FQ_XLEN-1:0] target;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Epoch-tagged instruction queue between fetch and decode.
// Stale responses are dropped; optional bypass when empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int XLEN      = FQ_XLEN,
  parameter int DEPTH     = FQ_DEPTH,
  parameter int EPOCH_W   = FQ_EPOCH_W,
  parameter int AF_MARGIN = 1,
  parameter int BYPASS    = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [EPOCH_W-1:0]         enq_epoch_i,
  input  logic [XLEN-1:0]            enq_pc_i,
  input  logic [XLEN-1:0]            enq_inst_i,
  input  logic [XLEN-1:0]            enq_pc_incr_i,
  input  exc_type_e                  enq_exc_i,
  input  logic                       enq_taken_i,
  input  logic [XLEN-1:0]            enq_target_i,
  output logic [EPOCH_W-1:0]         epoch_o,
  output logic                       deq_valid_o,
  input  logic                       deq_ready_i,
  output logic [XLEN-1:0]            deq_pc_o,
  output logic [XLEN-1:0]            deq_inst_o,
  output logic [XLEN-1:0]            deq_pc_incr_o,
  output exc_type_e                  deq_exc_o,
  output logic                       deq_taken_o,
  output logic [XLEN-1:0]            deq_target_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       almost_full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam bit BYP = (BYPASS != 0);

  fq_entry_t        mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [EPOCH_W-1:0] epoch;

  fq_entry_t enq_entry;
  fq_entry_t head;
  logic full;
  logic empty;
  logic enq_fire;
  logic keep;
  logic byp;
  logic deq_fire;
  logic wr_en;
  logic rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign enq_ready_o = !full && !rst_i && !flush_i;
  assign enq_fire    = enq_valid_i && enq_ready_o;
  assign keep        = enq_fire && (enq_epoch_i == epoch);

  assign enq_entry = '{
    pc:      enq_pc_i,
    inst:    enq_inst_i,
    pc_incr: enq_pc_incr_i,
    exc:     enq_exc_i,
    taken:   enq_taken_i,
    target:  enq_target_i
  };

  assign byp  = BYP && empty && keep;
  assign head = byp ? enq_entry : mem[rd_ptr];

  assign deq_valid_o = !rst_i && !flush_i && (!empty || byp);
  assign deq_fire    = deq_valid_o && deq_ready_i;

  // A bypassed entry consumed in its arrival cycle never touches storage.
  assign wr_en = keep && !(byp && deq_ready_i);
  assign rd_en = deq_fire && !byp;

  assign deq_pc_o      = head.pc;
  assign deq_inst_o    = head.inst;
  assign deq_pc_incr_o = head.pc_incr;
  assign deq_exc_o     = head.exc;
  assign deq_taken_o   = head.taken;
  assign deq_target_o  = head.target;

  assign epoch_o       = epoch;
  assign count_o       = count;
  assign almost_full_o = (count >= CW'(DEPTH - AF_MARGIN));

  // Entry storage; write enable is already gated by reset and flush.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr] <= enq_entry;
    end
  end

  // Pointers, occupancy and epoch; reset beats flush beats traffic.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      epoch  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      epoch  <= epoch + EPOCH_W'(1);
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios then random traffic.
// A queue model tracks accepted entries; a negedge monitor checks outputs.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int AFM   = 1;
  localparam int NEP   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       enq_valid = 1'b0;
  logic       deq_ready = 1'b0;
  logic [1:0] enq_epoch = '0;
  fq_entry_t  enq_e = '0;

  logic        enq_ready;
  logic [1:0]  epoch;
  logic        deq_valid;
  logic [31:0] deq_pc, deq_inst, deq_pc_incr, deq_target;
  exc_type_e   deq_exc;
  logic        deq_taken;
  logic [2:0]  count;
  logic        af;

  fetch_queue #(.BYPASS(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .enq_valid_i(enq_valid), .enq_ready_o(enq_ready),
    .enq_epoch_i(enq_epoch),
    .enq_pc_i(enq_e.pc), .enq_inst_i(enq_e.inst),
    .enq_pc_incr_i(enq_e.pc_incr), .enq_exc_i(enq_e.exc),
    .enq_taken_i(enq_e.taken), .enq_target_i(enq_e.target),
    .epoch_o(epoch),
    .deq_valid_o(deq_valid), .deq_ready_i(deq_ready),
    .deq_pc_o(deq_pc), .deq_inst_o(deq_inst),
    .deq_pc_incr_o(deq_pc_incr), .deq_exc_o(deq_exc),
    .deq_taken_o(deq_taken), .deq_target_o(deq_target),
    .count_o(count), .almost_full_o(af)
  );

  logic        nb_valid = 1'b0;
  logic        nb_ready = 1'b1;
  logic        nb_flush = 1'b0;
  logic [1:0]  nb_epoch_in = '0;
  logic [31:0] nb_pc = '0;
  logic        nb_enq_ready;
  logic [1:0]  nb_epoch;
  logic        nb_deq_valid;
  logic [31:0] nb_deq_pc, nb_deq_inst, nb_deq_pc_incr, nb_deq_target;
  exc_type_e   nb_deq_exc;
  logic        nb_deq_taken;
  logic [2:0]  nb_count;
  logic        nb_af;

  fetch_queue #(.BYPASS(0)) u_nb (
    .clk_i(clk), .rst_i(rst), .flush_i(nb_flush),
    .enq_valid_i(nb_valid), .enq_ready_o(nb_enq_ready),
    .enq_epoch_i(nb_epoch_in),
    .enq_pc_i(nb_pc), .enq_inst_i(32'h0000_0013),
    .enq_pc_incr_i(nb_pc + 32'd4), .enq_exc_i(EXC_NONE),
    .enq_taken_i(1'b0), .enq_target_i(32'h0),
    .epoch_o(nb_epoch),
    .deq_valid_o(nb_deq_valid), .deq_ready_i(nb_ready),
    .deq_pc_o(nb_deq_pc), .deq_inst_o(nb_deq_inst),
    .deq_pc_incr_o(nb_deq_pc_incr), .deq_exc_o(nb_deq_exc),
    .deq_taken_o(nb_deq_taken), .deq_target_o(nb_deq_target),
    .count_o(nb_count), .almost_full_o(nb_af)
  );

  fq_entry_t exp_q[$];
  int  m_epoch = 0;
  int  exp_count = 0;
  bit  pend_rst = 1'b0;
  bit  pend_flush = 1'b0;
  bit  run = 1'b0;
  int  vectors = 0;
  int  errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic fq_entry_t mk(input logic [31:0] pc);
    fq_entry_t e;
    e.pc      = pc;
    e.inst    = $urandom;
    e.pc_incr = pc + (($urandom_range(0, 1) != 0) ? 32'd2 : 32'd4);
    e.exc     = exc_type_e'($urandom_range(0, 4));
    e.taken   = 1'($urandom_range(0, 1));
    e.target  = $urandom;
    return e;
  endfunction

  // One clock of stimulus; the model queue holds every entry that
  // the rules say is kept, pushed at issue time.
  task automatic step(input bit r, input bit f, input bit v,
                      input bit stale, input logic [31:0] pc,
                      input bit dr);
    @(posedge clk);
    #1;
    if (pend_rst) begin
      exp_q.delete();
      m_epoch = 0;
    end else if (pend_flush) begin
      exp_q.delete();
      m_epoch = (m_epoch + 1) % NEP;
    end
    exp_count = exp_q.size();
    rst       = r;
    flush     = f;
    enq_valid = v;
    deq_ready = dr;
    enq_epoch = 2'(stale ? (m_epoch + NEP - 1) % NEP : m_epoch);
    enq_e     = mk(pc);
    if (v && !r && !f && exp_count < DEPTH && !stale)
      exp_q.push_back(enq_e);
    pend_rst   = r;
    pend_flush = f;
  endtask

  task automatic idle(input bit dr);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, dr);
  endtask

  task automatic enq(input logic [31:0] pc, input bit dr);
    step(1'b0, 1'b0, 1'b1, 1'b0, pc, dr);
  endtask

  // Monitor: handshake/state checks every cycle, entry checks on deq.
  always @(negedge clk) begin
    fq_entry_t a;
    fq_entry_t e;
    if (run) begin
      chk("enq_ready", 32'(enq_ready),
          32'(!rst && !flush && exp_count < DEPTH));
      chk("deq_valid", 32'(deq_valid),
          32'(!rst && !flush && exp_q.size() != 0));
      chk("count", 32'(count), 32'(exp_count));
      chk("almost_full", 32'(af), 32'(exp_count >= DEPTH - AFM));
      chk("epoch", 32'(epoch), 32'(m_epoch));
      if (deq_valid && deq_ready) begin
        if (exp_q.size() == 0) begin
          chk("deq_unexpected", 32'(deq_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          a = '{pc: deq_pc, inst: deq_inst, pc_incr: deq_pc_incr,
                exc: deq_exc, taken: deq_taken, target: deq_target};
          chk("deq_pc", a.pc, e.pc);
          vectors++;
          if (a !== e) begin
            errors++;
            $display("FAIL deq_entry: got %h expected %h", a, e);
          end
        end
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    run = 1'b1;

    // Non-bypass instance: head appears one cycle after the write.
    idle(1'b0);
    nb_pc    = 32'h8000_0100;
    nb_valid = 1'b1;
    @(negedge clk);
    chk("nb_same_cycle_valid", 32'(nb_deq_valid), 32'd0);
    chk("nb_enq_ready", 32'(nb_enq_ready), 32'd1);
    idle(1'b0);
    nb_valid = 1'b0;
    @(negedge clk);
    chk("nb_next_valid", 32'(nb_deq_valid), 32'd1);
    chk("nb_next_pc", nb_deq_pc, 32'h8000_0100);
    chk("nb_count", 32'(nb_count), 32'd1);
    idle(1'b0);
    @(negedge clk);
    chk("nb_drained", 32'(nb_deq_valid), 32'd0);

    // Reset in the middle of traffic.
    for (int i = 0; i < 3; i++) enq(32'h8000_0040 + 32'(4 * i), 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0050, 1'b1);
    idle(1'b0);

    // Fill, full with deq_ready, then refill across the wrap.
    for (int i = 0; i < 4; i++) enq(32'h8000_0000 + 32'(4 * i), 1'b0);
    enq(32'h8000_0010, 1'b1);
    idle(1'b1);
    enq(32'h8000_0014, 1'b0);
    enq(32'h8000_0018, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Same-cycle bypass on an empty queue.
    enq(32'h8000_0100, 1'b1);
    idle(1'b0);

    // Flush with entries queued, then stale and current enqueues.
    enq(32'h8000_0200, 1'b0);
    enq(32'h8000_0204, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_0208, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0300, 1'b1);
    enq(32'h8000_0304, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Epoch wraps back to zero after four redirects.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    enq(32'h8000_0400, 1'b0);
    idle(1'b1);

    // Simultaneous enq and deq at count 2.
    enq(32'h8000_0500, 1'b0);
    enq(32'h8000_0504, 1'b0);
    enq(32'h8000_0508, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 4) == 0,
           $urandom & 32'hFFFF_FFFE,
           $urandom_range(0, 9) < 6);
    end
    idle(1'b0);
    @(negedge clk);
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
